// File: rtl/traffic_pkg.sv
// Shared light codes, FSM state encodings, approach indices and round-robin helper.
// Latency: n/a (types, constants and a combinational function only).
// Backpressure: n/a.
package traffic_pkg;

  // Light codes are {R,Y,G}
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_ALLRED = 2'd3
  } state_t;

  localparam logic [1:0] NS = 2'd0;
  localparam logic [1:0] SN = 2'd1;
  localparam logic [1:0] EW = 2'd2;
  localparam logic [1:0] WE = 2'd3;

  // Skip-empty round robin: searches last+1 .. last+4 (mod 4).
  // Returns {found, index}; found=0 when no approach is requesting.
  function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [3:0] req);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!r[2] && req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

endpackage

// File: rtl/green_phase_scheduler_tick_prescaler.sv
// Timing-tick prescaler: one-cycle tick every TICK_DIV cycles, synchronous restart.
// Latency: tick is high on the TICK_DIV-th cycle after a restart (count starts at 0).
// Backpressure: none; free-running unless restarted.
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  // Cycle counter wraps on tick; restart forces it back to 0 so a new state starts a full tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          cnt_q <= '0;
    else if (restart)    cnt_q <= '0;
    else if (tick)       cnt_q <= '0;
    else                 cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/green_phase_scheduler.sv
// Round-robin green-phase scheduler: GREEN(sized by queue) -> YELLOW -> ALLRED per approach.
// Latency: grant one cycle after a request in IDLE; ALLRED end re-arbitrates with no idle gap.
// Backpressure: none; counts are sampled levels. Build option EMERGENCY_PREEMPT_EN adds preemption.
module green_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int GREEN_MIN = 2,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count_ns_4b,
  input  logic [3:0] count_sn_4b,
  input  logic [3:0] count_ew_4b,
  input  logic [3:0] count_we_4b,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic       emerg_req,
  input  logic [1:0] emerg_dir,
`endif
  output logic [2:0] tf_ns,
  output logic [2:0] tf_sn,
  output logic [2:0] tf_ew,
  output logic [2:0] tf_we,
  output logic [3:0] grant,
  output logic [1:0] phase,
  output logic       phase_start
);

  state_t          state_q, state_d;
  logic [1:0]      dir_q, dir_d;
  logic [1:0]      last_q, last_d;
  logic [3:0]      grant_q, grant_d;
  logic [3:0]      timer_q, timer_d;
  logic [3:0]      g_q, g_d;
  logic [3:0][2:0] tf_q, tf_d;
  logic            phase_start_q, phase_start_d;

  logic            tick, restart, go_green;
  logic [3:0][3:0] counts;
  logic [3:0]      req;
  logic [2:0]      arb;
  logic            pick_vld, pick_emerg, emerg_hold, emerg_preempt;
  logic [1:0]      pick_dir;
  logic [3:0]      pick_cnt, pick_g;

  assign counts = {count_we_4b, count_ew_4b, count_sn_4b, count_ns_4b};
  assign req    = {|count_we_4b, |count_ew_4b, |count_sn_4b, |count_ns_4b};
  assign arb    = rr_pick(last_q, req);

`ifdef EMERGENCY_PREEMPT_EN
  // An emergency request overrides arbitration; it also holds or preempts the current green.
  assign pick_vld      = emerg_req | arb[2];
  assign pick_dir      = emerg_req ? emerg_dir : arb[1:0];
  assign pick_emerg    = emerg_req;
  assign emerg_hold    = emerg_req && (emerg_dir == dir_q);
  assign emerg_preempt = emerg_req && (emerg_dir != dir_q);
`else
  assign pick_vld      = arb[2];
  assign pick_dir      = arb[1:0];
  assign pick_emerg    = 1'b0;
  assign emerg_hold    = 1'b0;
  assign emerg_preempt = 1'b0;
`endif

  // Green length is latched at grant time so later count changes cannot stretch a running green.
  assign pick_cnt = counts[pick_dir];
  assign pick_g   = pick_emerg                   ? 4'(GREEN_MIN) :
                    (pick_cnt < 4'(GREEN_MIN))   ? 4'(GREEN_MIN) :
                    (pick_cnt > 4'(GREEN_MAX))   ? 4'(GREEN_MAX) : pick_cnt;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  // Next-state logic: tick-counted phase timer, arbitration on IDLE and at ALLRED end
  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    last_d        = last_q;
    grant_d       = grant_q;
    timer_d       = timer_q;
    g_d           = g_q;
    restart       = 1'b0;
    go_green      = 1'b0;
    phase_start_d = 1'b0;
    tf_d          = {4{RED}};

    case (state_q)
      ST_IDLE: begin
        restart  = 1'b1;
        go_green = pick_vld;
      end
      ST_GREEN: begin
        if (emerg_preempt) begin
          state_d = ST_YELLOW;
          timer_d = '0;
          restart = 1'b1;
        end else if (tick) begin
          if (timer_q == g_q - 4'd1) begin
            if (!emerg_hold) begin
              state_d = ST_YELLOW;
              timer_d = '0;
              restart = 1'b1;
            end
          end else begin
            timer_d = timer_q + 4'd1;
          end
        end
      end
      ST_YELLOW: begin
        if (tick) begin
          if (timer_q == 4'(YELLOW_T - 1)) begin
            state_d = ST_ALLRED;
            timer_d = '0;
            restart = 1'b1;
          end else begin
            timer_d = timer_q + 4'd1;
          end
        end
      end
      ST_ALLRED: begin
        if (tick) begin
          if (timer_q == 4'(ALLRED_T - 1)) begin
            if (pick_vld) begin
              go_green = 1'b1;
            end else begin
              state_d = ST_IDLE;
              grant_d = '0;
              timer_d = '0;
              restart = 1'b1;
            end
          end else begin
            timer_d = timer_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_green) begin
      state_d       = ST_GREEN;
      dir_d         = pick_dir;
      last_d        = pick_dir;
      grant_d       = 4'b0001 << pick_dir;
      g_d           = pick_g;
      timer_d       = '0;
      restart       = 1'b1;
      phase_start_d = 1'b1;
    end

    for (int i = 0; i < 4; i++) begin
      if (dir_d == 2'(i) && state_d == ST_GREEN)       tf_d[i] = GREEN;
      else if (dir_d == 2'(i) && state_d == ST_YELLOW) tf_d[i] = YELLOW;
    end
  end

  // State and registered outputs; reset forces all-red IDLE with the search starting at ns
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      dir_q         <= NS;
      last_q        <= WE;
      grant_q       <= '0;
      timer_q       <= '0;
      g_q           <= '0;
      tf_q          <= {4{RED}};
      phase_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      last_q        <= last_d;
      grant_q       <= grant_d;
      timer_q       <= timer_d;
      g_q           <= g_d;
      tf_q          <= tf_d;
      phase_start_q <= phase_start_d;
    end
  end

  assign tf_ns       = tf_q[NS];
  assign tf_sn       = tf_q[SN];
  assign tf_ew       = tf_q[EW];
  assign tf_we       = tf_q[WE];
  assign grant       = grant_q;
  assign phase       = state_q;
  assign phase_start = phase_start_q;

endmodule
